// File: rtl/pag_ptcache.sv
// Page-translation cache: 16-entry direct-mapped page-table cache with
// memory refill handshake and sweep (invalidate-all).
module pag_ptcache (
    input  logic        clk3_vma_h,
    input  logic        mr_reset_h,
    input  logic [22:0] vma_13to35_h,
    input  logic        pag_req_h,
    input  logic        pag_req_write_h,
    input  logic        pag_req_user_h,
    input  logic        vma1_ac_ref_h,
    input  logic        pag_sweep_h,
    input  logic        pag_refill_ack_h,
    input  logic [15:0] pag_refill_data_h,
    output logic        pag_busy_h,
    output logic        pag_done_h,
    output logic        pag_fail_h,
    output logic [12:0] pag_pa_14to26_h,
    output logic        pag_refill_req_h,
    output logic [13:0] pag_refill_adr_h
);

    localparam int unsigned N_ENT  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TAG_W  = 10;
    localparam int unsigned PPN_W  = 13;
    localparam int unsigned PAGE_W = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_FILL,
        S_SWEEP
    } state_t;

    state_t              r_state;
    logic [PAGE_W-1:0]   r_page;
    logic                r_write;
    logic                r_user;
    logic                r_acref;
    logic                r_sweep_pend;
    logic [IDX_W-1:0]    r_cnt;
    logic [14:0]         r_rdata;

    logic [N_ENT-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag   [N_ENT];
    logic [N_ENT-1:0]    r_euser;
    logic [N_ENT-1:0]    r_ewr;
    logic [N_ENT-1:0]    r_epub;
    logic [PPN_W-1:0]    r_ppn   [N_ENT];

    logic                r_busy;
    logic                r_done;
    logic                r_fail;
    logic [PPN_W-1:0]    r_pa;
    logic                r_refill_req;
    logic [PAGE_W-1:0]   r_refill_adr;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_perm_fail;
    logic                w_unused;

    // Page number is VMA 13-26; offset bits VMA 27-35 play no part in translation.
    assign w_unused    = ^vma_13to35_h[8:0];
    assign w_idx       = r_page[IDX_W-1:0];
    assign w_tag       = r_page[PAGE_W-1:IDX_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_euser[w_idx] == r_user);
    assign w_perm_fail = (r_write && !r_ewr[w_idx]) || (r_user && !r_epub[w_idx]);

    // Control FSM, valid bits and all registered outputs.
    always_ff @(posedge clk3_vma_h or posedge mr_reset_h) begin
        if (mr_reset_h) begin
            r_state      <= S_IDLE;
            r_page       <= '0;
            r_write      <= 1'b0;
            r_user       <= 1'b0;
            r_acref      <= 1'b0;
            r_sweep_pend <= 1'b0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_valid      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_pa         <= '0;
            r_refill_req <= 1'b0;
            r_refill_adr <= '0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            r_pa   <= '0;
            if (r_state != S_IDLE && pag_sweep_h) begin
                r_sweep_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (pag_req_h && !r_sweep_pend) begin
                        r_page  <= vma_13to35_h[22:9];
                        r_write <= pag_req_write_h;
                        r_user  <= pag_req_user_h;
                        r_acref <= vma1_ac_ref_h;
                        r_state <= S_LOOKUP;
                        r_busy  <= 1'b1;
                        if (pag_sweep_h) begin
                            r_sweep_pend <= 1'b1;
                        end
                    end else if (r_sweep_pend || pag_sweep_h) begin
                        r_cnt   <= '0;
                        r_state <= S_SWEEP;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (r_acref) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hit) begin
                        r_done  <= 1'b1;
                        r_fail  <= w_perm_fail;
                        r_pa    <= w_perm_fail ? '0 : r_ppn[w_idx];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_refill_req <= 1'b1;
                        r_refill_adr <= r_page;
                        r_state      <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (pag_refill_ack_h) begin
                        r_refill_req <= 1'b0;
                        if (pag_refill_data_h[15]) begin
                            r_rdata <= pag_refill_data_h[14:0];
                            r_state <= S_FILL;
                        end else begin
                            r_done  <= 1'b1;
                            r_fail  <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    r_valid[w_idx] <= 1'b1;
                    r_state        <= S_LOOKUP;
                end
                S_SWEEP: begin
                    r_valid[r_cnt] <= 1'b0;
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_sweep_pend <= 1'b0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Entry payload; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk3_vma_h) begin
        if (r_state == S_FILL) begin
            r_tag[w_idx]   <= w_tag;
            r_euser[w_idx] <= r_user;
            r_ewr[w_idx]   <= r_rdata[14];
            r_epub[w_idx]  <= r_rdata[13];
            r_ppn[w_idx]   <= r_rdata[12:0];
        end
    end

    assign pag_busy_h       = r_busy;
    assign pag_done_h       = r_done;
    assign pag_fail_h       = r_fail;
    assign pag_pa_14to26_h  = r_pa;
    assign pag_refill_req_h = r_refill_req;
    assign pag_refill_adr_h = r_refill_adr;

endmodule
